// File: rtl/alu_seq_src2.sv
// Sequential ALU stage fed by the source-2 immediate extender.
// Add, subtract, logic and compare finish in one cycle. Shifts run on an
// iterative one-bit-per-cycle shifter, so their latency grows with the
// shift amount. A start/busy/done handshake lets the control unit stall.
module alu_seq_src2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  ALUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;

  logic [31:0] quick_result;
  logic [31:0] shift_next;
  logic        is_shift_op;
  logic        needs_iteration;
  logic [4:0]  shamt;

  assign shamt           = SrcB[4:0];
  assign is_shift_op     = (ALUOp == OP_SLL) || (ALUOp == OP_SRL) || (ALUOp == OP_SRA);
  assign needs_iteration = is_shift_op && (shamt != 5'd0);

  // Single-cycle result; a zero-amount shift simply passes operand A through.
  always_comb begin
    quick_result = 32'd0;
    case (ALUOp)
      OP_ADD:  quick_result = SrcA + SrcB;
      OP_SUB:  quick_result = SrcA - SrcB;
      OP_AND:  quick_result = SrcA & SrcB;
      OP_OR:   quick_result = SrcA | SrcB;
      OP_SLT:  quick_result = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
      default: quick_result = SrcA;
    endcase
  end

  // One-bit step of the iterative shifter, using the opcode latched at accept.
  always_comb begin
    shift_next = acc_q;
    case (op_q)
      OP_SLL:  shift_next = {acc_q[30:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, acc_q[31:1]};
      OP_SRA:  shift_next = {acc_q[31], acc_q[31:1]};
      default: shift_next = acc_q;
    endcase
  end

  // State register; reset aborts any shift in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE so requests while busy drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = needs_iteration ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the registered state.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath next values; Result only changes on the completing edge.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (needs_iteration) begin
            acc_d = SrcA;
            cnt_d = shamt;
            op_d  = ALUOp;
          end else begin
            result_d = quick_result;
          end
        end
      end
      SHIFT: begin
        acc_d = shift_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d = shift_next;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, cleared by reset so an aborted shift leaves Result at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      op_q     <= OP_ADD;
      result_q <= 32'd0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign Result = result_q;
  assign Zero   = (result_q == 32'd0);

endmodule

// File: tb/tb_alu_seq_src2.sv
// Directed-vector bench for alu_seq_src2 with hand-computed expectations.
module tb_alu_seq_src2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  ALUOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] Result;
  logic        Zero;
  logic        busy;
  logic        done;

  int testsRun;
  int testsFailed;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  alu_seq_src2 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ALUOp  (ALUOp),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Result (Result),
    .Zero   (Zero),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request and wait (bounded) for its done pulse. Called at
  // 1 ns after a rising edge; returns 1 ns after the edge following done.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expResult, input int expEdges);
    int edges;
    int busyCnt;
    ALUOp = op;
    SrcA  = a;
    SrcB  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    edges   = 1;
    busyCnt = 0;
    while (!done && edges < 40) begin
      if (busy) busyCnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    if (done) busyCnt++;
    checkOutput({tag, "_result"}, Result, expResult);
    checkOutput({tag, "_zero"}, {31'd0, Zero}, {31'd0, (expResult == 32'd0)});
    checkOutput({tag, "_edges"}, edges, expEdges);
    checkOutput({tag, "_busycycles"}, busyCnt, expEdges);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_after"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_result_hold"}, Result, expResult);
  endtask

  // Main directed sequence.
  initial begin
    int doneCnt;
    int doneEdge;
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    start = 1'b0;
    ALUOp = OP_ADD;
    SrcA  = 32'd0;
    SrcB  = 32'd0;
    #1;
    checkOutput("reset_result", Result, 32'd0);
    checkOutput("reset_zero", {31'd0, Zero}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("add_sw_offset", OP_ADD, 32'h0000_0010, 32'h0000_0FFC, 32'h0000_100C, 1);
    applyStimulus("sra_31", OP_SRA, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32);
    applyStimulus("sll_0", OP_SLL, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1);
    applyStimulus("srl_4", OP_SRL, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 5);
    applyStimulus("sub_eq", OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1);
    applyStimulus("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1);
    applyStimulus("and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
    applyStimulus("slt_neg", OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    applyStimulus("sra_pos_3", OP_SRA, 32'h4000_0000, 32'h0000_0023, 32'h0800_0000, 4);
    applyStimulus("slt_true", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);

    // start held high through a shift by 8 while operands change underneath.
    ALUOp = OP_SLL;
    SrcA  = 32'h0000_0003;
    SrcB  = 32'h0000_0008;
    start = 1'b1;
    @(posedge clk);
    #1;
    doneCnt  = 0;
    doneEdge = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        checkOutput("held_result_midshift", Result, 32'h0000_0001);
        ALUOp = OP_ADD;
        SrcA  = 32'hFFFF_FFFF;
        SrcB  = 32'h0000_0002;
      end
      if (done) begin
        doneCnt++;
        if (doneEdge == 0) doneEdge = i;
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checkOutput("held_done_count", doneCnt, 32'd1);
    checkOutput("held_done_edge", doneEdge, 32'd9);
    checkOutput("held_result", Result, 32'h0000_0300);

    // Reset pulsed in the third cycle of a shift by 20.
    ALUOp = OP_SRL;
    SrcA  = 32'hABCD_0000;
    SrcB  = 32'h0000_0014;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_result", Result, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_zero", {31'd0, Zero}, 32'd1);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    doneCnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) doneCnt++;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_no_done", doneCnt, 32'd0);

    applyStimulus("or_after_abort", OP_OR, 32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
